cache_port_arbiter: RTL
=======================

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requesters sharing the cache controller port; legal range 2..8.
REQ-002 Parameter ADDRESS_WIDTH, default 32: request address width.
REQ-003 Parameter DATA_WIDTH, default 32: read and write data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT cycles allowed before a transaction is aborted; legal range 1..65535.
REQ-005 clk  in  1  clock; all logic samples on the rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 port_req  in  NUM_PORTS  per-port request; held high until grant.
REQ-008 port_read / port_write  in  NUM_PORTS each  per-port operation; exactly one is high with port_req.
REQ-009 port_addr  in  NUM_PORTS*ADDRESS_WIDTH  packed per-port address; port i occupies slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-010 port_wdata  in  NUM_PORTS*DATA_WIDTH  packed per-port write data, same packing as port_addr.
REQ-011 port_grant  out  NUM_PORTS  one-hot acceptance pulse.
REQ-012 port_done  out  NUM_PORTS  one-hot completion pulse.
REQ-013 port_error  out  NUM_PORTS  one-hot pulse for a malformed or timed-out request.
REQ-014 port_rdata  out  DATA_WIDTH  data from the last completed read.
REQ-015 ctrl_request  out  1  single-cycle request to the cache controller.
REQ-016 ctrl_read / ctrl_write / ctrl_addr / ctrl_wdata  out  1/1/ADDRESS_WIDTH/DATA_WIDTH  latched transaction fields.
REQ-017 ctrl_done  in  1  controller completion strobe.
REQ-018 ctrl_rdata  in  DATA_WIDTH  controller read data, valid with ctrl_done.
REQ-019 busy  out  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM shall have four states: IDLE, ISSUE, WAIT and RESPOND; all outputs shall be registered.
REQ-021 In IDLE, the valid requester (port_req=1 with port_read XOR port_write) found first scanning upward from rr_ptr, modulo NUM_PORTS, shall be selected; its index, read, write, addr and wdata shall be latched and the state shall go to ISSUE.
REQ-022 In IDLE, every port with port_req=1 and port_read==port_write shall get a one-cycle port_error pulse in the following cycle and shall not be selected; a valid request arbitrated in the same cycle shall proceed normally.
REQ-023 In ISSUE (one cycle), port_grant[owner]=1 and ctrl_request=1; the next state shall be WAIT.
REQ-024 ctrl_read, ctrl_write, ctrl_addr and ctrl_wdata shall hold the latched values from ISSUE through the end of WAIT; they shall be zero in IDLE.
REQ-025 In WAIT, ctrl_done=1 shall move the state to RESPOND and, for a read, capture ctrl_rdata into port_rdata; for a write, port_rdata shall be unchanged.
REQ-026 ctrl_done shall be ignored in IDLE, ISSUE and RESPOND.
REQ-027 In RESPOND (one cycle), port_done[owner]=1; rr_ptr shall become (owner+1) mod NUM_PORTS; the next state shall be IDLE.
REQ-028 Minimum latency: request seen in cycle 0 -> grant and ctrl_request in cycle 1 -> WAIT in cycle 2 (ctrl_done sampled) -> port_done in cycle 3 -> next arbitration in cycle 4.
REQ-029 A 16-bit timeout counter shall clear on entry to WAIT and increment each WAIT cycle without ctrl_done.
REQ-030 When TIMEOUT_CYCLES WAIT cycles have elapsed without ctrl_done, the block shall:
- pulse port_error[owner] for one cycle;
- leave port_done at zero and rr_ptr advanced as in REQ-027;
- return to IDLE.
REQ-031 If ctrl_done arrives in the same cycle the timeout is reached, ctrl_done shall win.
REQ-032 Deassertion of port_req after grant shall not cancel the transaction; new port_req values are sampled only in IDLE.
REQ-033 port_rdata shall hold its value between reads.

Reset
REQ-034 When reset_n is low, asynchronously:
- state=IDLE, rr_ptr=0, timeout counter=0;
- all port_* and ctrl_* outputs, port_rdata and busy shall be 0.
REQ-035 Reset asserted mid-transaction shall abandon it without port_done or port_error; after release, the first arbitration shall start from port 0.

Verification
REQ-036 Port 0 reads addr 0x100, controller returns ctrl_done with 0xDEADBEEF in the first WAIT cycle -> grant[0] in cycle 1, port_done[0] in cycle 3, port_rdata=0xDEADBEEF.
REQ-037 Ports 0 and 1 both request continuously from reset -> grants alternate 0,1,0,1 with no port granted twice in succession.
REQ-038 Port 1 raises port_req with port_read=1 and port_write=1 -> port_error[1] pulses once, no ctrl_request is issued.
REQ-039 TIMEOUT_CYCLES=4 with ctrl_done never asserted -> port_error[owner] one cycle after the 4th WAIT cycle, then IDLE; ctrl_done on the 4th WAIT cycle -> port_done instead.
REQ-040 Port 0 writes 0x12345678 to 0x40, and the bench deasserts port_req right after grant -> ctrl_write=1 and ctrl_wdata=0x12345678 stable until ctrl_done; port_rdata unchanged.
REQ-041 reset_n pulsed low during WAIT -> all outputs immediately 0; after release, a new request on port 1 is granted normally.

Source files
------------

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_port_arbiter
// Purpose  : Round-robin arbiter sharing one cache controller port between
//            NUM_PORTS requesters, with malformed-request and timeout errors.
// Revision : 1.0 - initial release
// ============================================================================
module cache_port_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_PORTS-1:0]               port_req,
    input  logic [NUM_PORTS-1:0]               port_read,
    input  logic [NUM_PORTS-1:0]               port_write,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    port_wdata,
    output logic [NUM_PORTS-1:0]               port_grant,
    output logic [NUM_PORTS-1:0]               port_done,
    output logic [NUM_PORTS-1:0]               port_error,
    output logic [DATA_WIDTH-1:0]              port_rdata,
    output logic                               ctrl_request,
    output logic                               ctrl_read,
    output logic                               ctrl_write,
    output logic [ADDRESS_WIDTH-1:0]           ctrl_addr,
    output logic [DATA_WIDTH-1:0]              ctrl_wdata,
    input  logic                               ctrl_done,
    input  logic [DATA_WIDTH-1:0]              ctrl_rdata,
    output logic                               busy
);

    localparam int          PTR_W        = $clog2(NUM_PORTS);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     owner_next;
    logic [PTR_W-1:0]     sel_idx;
    logic                 sel_found;
    logic [NUM_PORTS-1:0] malformed;
    logic [NUM_PORTS-1:0] sel_onehot;
    logic [NUM_PORTS-1:0] owner_onehot;
    logic [15:0]          tcount;
    logic                 timeout_hit;

    // Round-robin scan starting at rr_ptr; malformed requests are never picked.
    always_comb begin
        int j;
        j         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        malformed = port_req & ~(port_read ^ port_write);
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            if (!sel_found && port_req[j] && (port_read[j] ^ port_write[j])) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(j);
            end
        end
    end

    assign sel_onehot   = ONE << sel_idx;
    assign owner_onehot = ONE << owner;
    assign owner_next   = (owner == PTR_W'(NUM_PORTS - 1)) ? '0 : owner + PTR_W'(1);
    // ctrl_done on the final WAIT cycle takes priority over the timeout.
    assign timeout_hit  = (state == WAIT) && !ctrl_done && (tcount == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (sel_found) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (ctrl_done) begin
                    state_next = RESPOND;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Every output is driven from this register stage, so each pulse lines up
    // with the state it belongs to rather than the state that produced it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= '0;
            owner        <= '0;
            tcount       <= '0;
            port_grant   <= '0;
            port_done    <= '0;
            port_error   <= '0;
            port_rdata   <= '0;
            ctrl_request <= 1'b0;
            ctrl_read    <= 1'b0;
            ctrl_write   <= 1'b0;
            ctrl_addr    <= '0;
            ctrl_wdata   <= '0;
            busy         <= 1'b0;
        end else begin
            port_grant   <= '0;
            port_done    <= '0;
            port_error   <= '0;
            ctrl_request <= 1'b0;
            busy         <= (state_next != IDLE);
            unique case (state)
                IDLE: begin
                    port_error <= malformed;
                    if (sel_found) begin
                        owner        <= sel_idx;
                        port_grant   <= sel_onehot;
                        ctrl_request <= 1'b1;
                        ctrl_read    <= port_read[sel_idx];
                        ctrl_write   <= port_write[sel_idx];
                        ctrl_addr    <= port_addr[sel_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        ctrl_wdata   <= port_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ISSUE: begin
                    tcount <= '0;
                end
                WAIT: begin
                    if (ctrl_done || timeout_hit) begin
                        ctrl_read  <= 1'b0;
                        ctrl_write <= 1'b0;
                        ctrl_addr  <= '0;
                        ctrl_wdata <= '0;
                    end
                    if (ctrl_done) begin
                        port_done <= owner_onehot;
                        if (ctrl_read) begin
                            port_rdata <= ctrl_rdata;
                        end
                    end else if (timeout_hit) begin
                        port_error <= owner_onehot;
                        rr_ptr     <= owner_next;
                    end else begin
                        tcount <= tcount + 16'd1;
                    end
                end
                RESPOND: begin
                    rr_ptr <= owner_next;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
